alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sequencer directly upstream of the 8-bit ALU functional units: arithmetic unit, gate unit and shift unit.
- Accepts one command (opcode, A, B) on a valid/ready handshake, decodes the target unit and drives the shared Opcode/A/B/Select bus for exactly one cycle.
- Captures the selected unit's registered result and Flag, then returns a response on a second valid/ready handshake.
- One command in flight at a time.

Parameters:
- WIDTH, 8, operand/result width; must match the functional units.
- ARITH_SEL, 3'b001, Select code for the arithmetic unit.
- GATE_SEL, 3'b010, Select code for the gate unit.
- SHIFT_SEL, 3'b100, Select code for the shift unit.

Ports:
- Clk  in  1  single clock, all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- Cmd_Valid  in  1  command present.
- Cmd_Ready  out  1  controller can accept a command.
- Cmd_Opcode  in  4  operation code.
- Cmd_A  in  WIDTH  operand A.
- Cmd_B  in  WIDTH  operand B.
- Opcode  out  4  opcode to the units.
- A  out  WIDTH  operand A to the units.
- B  out  WIDTH  operand B to the units.
- Select  out  3  unit select; 3'b000 = no unit.
- Arith_Result / Gate_Result / Shift_Result  in  WIDTH each  registered unit results.
- Arith_Flag / Gate_Flag / Shift_Flag  in  1 each  unit "valid op" flags.
- Rsp_Valid  out  1  response present.
- Rsp_Ready  in  1  consumer accepts the response.
- Rsp_Result  out  WIDTH  captured result.
- Rsp_Err  out  1  reserved opcode, or unit Flag=0.

Behaviour:
- Reset is synchronous and active-high on Clk (Reset sampled at posedge only). Reset values: state=IDLE, Cmd_Ready=1, Select=0, Opcode=0, A=0, B=0, Rsp_Valid=0, Rsp_Result=0, Rsp_Err=0.
- Opcode decode:
  - 0000-0101 -> ARITH_SEL.
  - 0110-1011 -> GATE_SEL.
  - 1100-1101 -> SHIFT_SEL.
  - 1110-1111 -> reserved.
- FSM states: IDLE, EXEC, CAPT, RESP. All outputs are registered.
- IDLE: Cmd_Ready=1.
  - On Cmd_Valid, legal opcode: latch Opcode/A/B from Cmd_*, set Select to the decoded code, go to EXEC.
  - On Cmd_Valid, reserved opcode: set Rsp_Result=0, Rsp_Err=1, Rsp_Valid=1, go to RESP; no unit is issued.
- EXEC: one cycle, Cmd_Ready=0. The units sample the bus at the edge that ends EXEC. At that edge Select returns to 0; Opcode/A/B hold their values. Go to CAPT.
- CAPT: one cycle. Sample the selected unit's Result and Flag (latched Select code picks the unit). Rsp_Result=unit result; Rsp_Err=~unit Flag; Rsp_Valid=1. Go to RESP.
- RESP: hold Rsp_* stable while Rsp_Valid && !Rsp_Ready. On Rsp_Ready: Rsp_Valid=0, Cmd_Ready=1, go to IDLE.
- Latency:
  - Legal command: accept edge -> Rsp_Valid high 3 edges later.
  - Reserved command: 1 edge.
  - Throughput: 1 command per 4 cycles minimum.
- Cmd_Valid while Cmd_Ready=0 is ignored; the command is not consumed.
- Rsp_Ready while Rsp_Valid=0 has no effect.
- Reset in any state: all outputs return to reset values next edge; the in-flight command and any pending response are dropped.
- Select is nonzero for exactly one cycle per legal command and is never two-hot.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- Defined: adds outputs Stat_Ops (16-bit) and Stat_Errs (16-bit).
  - Stat_Ops increments on each response handshake (Rsp_Valid && Rsp_Ready).
  - Stat_Errs increments on each such handshake with Rsp_Err=1.
  - Both saturate at 16'hFFFF; both clear on Reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - 4-bit opcode constants, including the gate set: AND 0110, NAND 0111, OR 1000, NOR 1001, XOR 1010, XNOR 1011.
  - Select codes ARITH_SEL/GATE_SEL/SHIFT_SEL/NONE_SEL.
  - FSM state enum (IDLE, EXEC, CAPT, RESP).
- One sub-module, alu_opcode_decode: combinational, opcode -> {select[2:0], reserved}. It is reused by any later unit that needs the opcode-to-unit mapping.

Test Plan:
- Gate op: Cmd_Opcode=0110, A=8'hF0, B=8'h3C, gate model returns 8'h30 with Flag=1.
  - Select=010 for exactly 1 cycle.
  - Rsp_Valid 3 edges after accept; Rsp_Result=8'h30, Rsp_Err=0.
- Reserved op: Cmd_Opcode=1111 -> Select stays 000; Rsp_Valid next edge with Rsp_Result=0, Rsp_Err=1.
- Unit Flag=0: shift opcode 1100 with Shift_Flag=0, Shift_Result=8'hAA -> Rsp_Result=8'hAA, Rsp_Err=1.
- Backpressure: hold Rsp_Ready=0 for 5 cycles after Rsp_Valid.
  - Rsp_* stable and Cmd_Ready=0 throughout; a second Cmd_Valid is not consumed.
  - On Rsp_Ready=1: Cmd_Ready=1 next cycle.
- Reset mid-op: assert Reset during EXEC -> next edge all outputs at reset values, no Rsp_Valid ever for that command.
- Stats (ALU_ISSUE_STATS_EN): 3 legal ops + 2 reserved -> Stat_Ops=5, Stat_Errs=2.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU definitions: opcode map, unit select codes and issue-controller FSM states.
package alu_pkg;

  // Arithmetic unit opcodes occupy 0000-0101
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADC  = 4'b0010;
  localparam logic [3:0] OP_SBB  = 4'b0011;
  localparam logic [3:0] OP_INC  = 4'b0100;
  localparam logic [3:0] OP_DEC  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_NAND = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_XNOR = 4'b1011;
  localparam logic [3:0] OP_SHL  = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_RSV0 = 4'b1110;
  localparam logic [3:0] OP_RSV1 = 4'b1111;

  localparam logic [2:0] NONE_SEL  = 3'b000;
  localparam logic [2:0] ARITH_SEL = 3'b001;
  localparam logic [2:0] GATE_SEL  = 3'b010;
  localparam logic [2:0] SHIFT_SEL = 3'b100;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CAPT = 2'd2, RESP = 2'd3} state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, unit-bus and response signals between the issue controller and its environment.
interface alu_issue_ctrl_if #(parameter int WIDTH = 8);
  logic             Cmd_Valid;
  logic             Cmd_Ready;
  logic [3:0]       Cmd_Opcode;
  logic [WIDTH-1:0] Cmd_A;
  logic [WIDTH-1:0] Cmd_B;
  logic [3:0]       Opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       Select;
  logic [WIDTH-1:0] Arith_Result;
  logic [WIDTH-1:0] Gate_Result;
  logic [WIDTH-1:0] Shift_Result;
  logic             Arith_Flag;
  logic             Gate_Flag;
  logic             Shift_Flag;
  logic             Rsp_Valid;
  logic             Rsp_Ready;
  logic [WIDTH-1:0] Rsp_Result;
  logic             Rsp_Err;

  modport master (
    input  Cmd_Valid, Cmd_Opcode, Cmd_A, Cmd_B,
    input  Arith_Result, Gate_Result, Shift_Result,
    input  Arith_Flag, Gate_Flag, Shift_Flag, Rsp_Ready,
    output Cmd_Ready, Opcode, A, B, Select,
    output Rsp_Valid, Rsp_Result, Rsp_Err
  );

  modport slave (
    output Cmd_Valid, Cmd_Opcode, Cmd_A, Cmd_B,
    output Arith_Result, Gate_Result, Shift_Result,
    output Arith_Flag, Gate_Flag, Shift_Flag, Rsp_Ready,
    input  Cmd_Ready, Opcode, A, B, Select,
    input  Rsp_Valid, Rsp_Result, Rsp_Err
  );
endinterface

// File: rtl/alu_issue_ctrl_opcode_decode.sv
// Combinational opcode-to-unit mapping shared by the issue controller and later units.
module alu_opcode_decode #(
  parameter logic [2:0] ARITH_SEL = alu_pkg::ARITH_SEL,
  parameter logic [2:0] GATE_SEL  = alu_pkg::GATE_SEL,
  parameter logic [2:0] SHIFT_SEL = alu_pkg::SHIFT_SEL
) (
  input  logic [3:0] opcode,
  output logic [2:0] select,
  output logic       reserved
);
  import alu_pkg::*;

  always_comb begin
    select   = NONE_SEL;
    reserved = 1'b0;
    if (opcode <= OP_DEC)       select = ARITH_SEL;
    else if (opcode <= OP_XNOR) select = GATE_SEL;
    else if (opcode <= OP_SHR)  select = SHIFT_SEL;
    else                        reserved = 1'b1;
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the arithmetic/gate/shift units: one command in flight, registered outputs.
// Optional ALU_ISSUE_STATS_EN adds saturating response/error counters Stat_Ops and Stat_Errs.
module alu_issue_ctrl #(
  parameter int         WIDTH     = 8,
  parameter logic [2:0] ARITH_SEL = alu_pkg::ARITH_SEL,
  parameter logic [2:0] GATE_SEL  = alu_pkg::GATE_SEL,
  parameter logic [2:0] SHIFT_SEL = alu_pkg::SHIFT_SEL
) (
  input  logic               Clk,
  input  logic               Reset,
  alu_issue_ctrl_if.master   bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]        Stat_Ops,
  output logic [15:0]        Stat_Errs
`endif
);
  import alu_pkg::*;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_CAPT = CAPT;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]       state;
  logic [2:0]       unit_sel;
  logic [2:0]       dec_select;
  logic             dec_reserved;
  logic [WIDTH-1:0] unit_res;
  logic             unit_flag;

  alu_opcode_decode #(
    .ARITH_SEL (ARITH_SEL),
    .GATE_SEL  (GATE_SEL),
    .SHIFT_SEL (SHIFT_SEL)
  ) u_decode (
    .opcode   (bus.Cmd_Opcode),
    .select   (dec_select),
    .reserved (dec_reserved)
  );

  // Select is cleared after EXEC, so capture uses the separately latched unit code.
  always_comb begin
    unit_res  = '0;
    unit_flag = 1'b0;
    if (unit_sel == ARITH_SEL) begin
      unit_res  = bus.Arith_Result;
      unit_flag = bus.Arith_Flag;
    end else if (unit_sel == GATE_SEL) begin
      unit_res  = bus.Gate_Result;
      unit_flag = bus.Gate_Flag;
    end else if (unit_sel == SHIFT_SEL) begin
      unit_res  = bus.Shift_Result;
      unit_flag = bus.Shift_Flag;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= S_IDLE;
      unit_sel       <= NONE_SEL;
      bus.Cmd_Ready  <= 1'b1;
      bus.Select     <= NONE_SEL;
      bus.Opcode     <= '0;
      bus.A          <= '0;
      bus.B          <= '0;
      bus.Rsp_Valid  <= 1'b0;
      bus.Rsp_Result <= '0;
      bus.Rsp_Err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Cmd_Valid) begin
            bus.Cmd_Ready <= 1'b0;
            if (dec_reserved) begin
              bus.Rsp_Result <= '0;
              bus.Rsp_Err    <= 1'b1;
              bus.Rsp_Valid  <= 1'b1;
              state          <= S_RESP;
            end else begin
              bus.Opcode <= bus.Cmd_Opcode;
              bus.A      <= bus.Cmd_A;
              bus.B      <= bus.Cmd_B;
              bus.Select <= dec_select;
              unit_sel   <= dec_select;
              state      <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          bus.Select <= NONE_SEL;
          state      <= S_CAPT;
        end
        S_CAPT: begin
          bus.Rsp_Result <= unit_res;
          bus.Rsp_Err    <= ~unit_flag;
          bus.Rsp_Valid  <= 1'b1;
          state          <= S_RESP;
        end
        default: begin
          if (bus.Rsp_Ready) begin
            bus.Rsp_Valid <= 1'b0;
            bus.Cmd_Ready <= 1'b1;
            state         <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Stat_Ops  <= '0;
      Stat_Errs <= '0;
    end else if (bus.Rsp_Valid && bus.Rsp_Ready) begin
      Stat_Ops <= sat_inc(Stat_Ops);
      if (bus.Rsp_Err) Stat_Errs <= sat_inc(Stat_Errs);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with simple registered unit models on the shared bus.
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic shift_flag_cfg;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_issue_ctrl_if #(.WIDTH(8)) bus ();

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops, stat_errs;
`endif

  alu_issue_ctrl #(.WIDTH(8)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .Stat_Ops  (stat_ops),
    .Stat_Errs (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  // Unit models: sample the bus on the edge ending EXEC, present a registered result.
  always @(posedge clk) begin
    if (rst) begin
      bus.Arith_Result <= '0; bus.Arith_Flag <= 1'b0;
      bus.Gate_Result  <= '0; bus.Gate_Flag  <= 1'b0;
      bus.Shift_Result <= '0; bus.Shift_Flag <= 1'b0;
    end else begin
      if (bus.Select == 3'b001) begin
        bus.Arith_Result <= (bus.Opcode == 4'b0000) ? bus.A + bus.B : bus.A - bus.B;
        bus.Arith_Flag   <= 1'b1;
      end
      if (bus.Select == 3'b010) begin
        case (bus.Opcode)
          4'b0110: bus.Gate_Result <= bus.A & bus.B;
          4'b0111: bus.Gate_Result <= ~(bus.A & bus.B);
          4'b1000: bus.Gate_Result <= bus.A | bus.B;
          4'b1001: bus.Gate_Result <= ~(bus.A | bus.B);
          4'b1010: bus.Gate_Result <= bus.A ^ bus.B;
          4'b1011: bus.Gate_Result <= ~(bus.A ^ bus.B);
          default: bus.Gate_Result <= '0;
        endcase
        bus.Gate_Flag <= 1'b1;
      end
      if (bus.Select == 3'b100) begin
        bus.Shift_Result <= (bus.Opcode == 4'b1100) ? bus.A << 1 : bus.A >> 1;
        bus.Shift_Flag   <= shift_flag_cfg;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int exp_lat, input logic [7:0] exp_res,
                         input logic exp_err);
    int lat;
    bus.Cmd_Valid = 1'b1; bus.Cmd_Opcode = op; bus.Cmd_A = a; bus.Cmd_B = b;
    tick;
    bus.Cmd_Valid = 1'b0;
    lat = 1;
    while (!bus.Rsp_Valid && lat < 8) begin
      tick;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, bus.Rsp_Result, exp_res);
    check_eq({tag, "_err"}, bus.Rsp_Err, exp_err);
    bus.Rsp_Ready = 1'b1;
    tick;
    bus.Rsp_Ready = 1'b0;
    check_eq({tag, "_done"}, {bus.Rsp_Valid, bus.Cmd_Ready}, 2'b01);
  endtask

  initial begin
    rst = 1'b1;
    shift_flag_cfg = 1'b1;
    bus.Cmd_Valid = 1'b0; bus.Cmd_Opcode = '0; bus.Cmd_A = '0; bus.Cmd_B = '0;
    bus.Rsp_Ready = 1'b0;
    tick; tick;
    check_eq("rst_cmd_ready", bus.Cmd_Ready, 1'b1);
    check_eq("rst_select", bus.Select, 3'b000);
    check_eq("rst_bus", {bus.Opcode, bus.A, bus.B}, 20'h0);
    check_eq("rst_rsp", {bus.Rsp_Valid, bus.Rsp_Err, bus.Rsp_Result}, 10'h0);
    rst = 1'b0;
    tick;

    // Gate AND: F0 & 3C = 30
    bus.Cmd_Valid = 1'b1; bus.Cmd_Opcode = 4'b0110; bus.Cmd_A = 8'hF0; bus.Cmd_B = 8'h3C;
    tick;
    bus.Cmd_Valid = 1'b0;
    check_eq("and_sel_on", bus.Select, 3'b010);
    check_eq("and_busy", bus.Cmd_Ready, 1'b0);
    check_eq("and_bus", {bus.Opcode, bus.A, bus.B}, 20'h6F03C);
    check_eq("and_vld_e1", bus.Rsp_Valid, 1'b0);
    tick;
    check_eq("and_sel_off", bus.Select, 3'b000);
    check_eq("and_bus_hold", {bus.Opcode, bus.A, bus.B}, 20'h6F03C);
    check_eq("and_vld_e2", bus.Rsp_Valid, 1'b0);
    tick;
    check_eq("and_vld_e3", bus.Rsp_Valid, 1'b1);
    check_eq("and_res", bus.Rsp_Result, 8'h30);
    check_eq("and_err", bus.Rsp_Err, 1'b0);
    check_eq("and_sel_idle", bus.Select, 3'b000);
    bus.Rsp_Ready = 1'b1;
    tick;
    bus.Rsp_Ready = 1'b0;
    check_eq("and_done", {bus.Rsp_Valid, bus.Cmd_Ready}, 2'b01);

    // Reserved opcode answers on the accept edge without issuing
    bus.Cmd_Valid = 1'b1; bus.Cmd_Opcode = 4'b1111; bus.Cmd_A = 8'h11; bus.Cmd_B = 8'h22;
    tick;
    bus.Cmd_Valid = 1'b0;
    check_eq("rsv_sel", bus.Select, 3'b000);
    check_eq("rsv_vld", bus.Rsp_Valid, 1'b1);
    check_eq("rsv_res", bus.Rsp_Result, 8'h00);
    check_eq("rsv_err", bus.Rsp_Err, 1'b1);
    check_eq("rsv_busy", bus.Cmd_Ready, 1'b0);
    bus.Rsp_Ready = 1'b1;
    tick;
    bus.Rsp_Ready = 1'b0;
    check_eq("rsv_done", {bus.Rsp_Valid, bus.Cmd_Ready}, 2'b01);

    // Shift with Flag=0: 55 << 1 = AA, error; then backpressure
    shift_flag_cfg = 1'b0;
    bus.Cmd_Valid = 1'b1; bus.Cmd_Opcode = 4'b1100; bus.Cmd_A = 8'h55; bus.Cmd_B = 8'h01;
    tick;
    bus.Cmd_Valid = 1'b0;
    check_eq("shl_sel_on", bus.Select, 3'b100);
    tick; tick;
    check_eq("shl_vld", bus.Rsp_Valid, 1'b1);
    check_eq("shl_res", bus.Rsp_Result, 8'hAA);
    check_eq("shl_err", bus.Rsp_Err, 1'b1);
    bus.Cmd_Valid = 1'b1; bus.Cmd_Opcode = 4'b0000; bus.Cmd_A = 8'h01; bus.Cmd_B = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick;
      check_eq("bp_rsp", {bus.Rsp_Valid, bus.Rsp_Err, bus.Rsp_Result}, 10'h3AA);
      check_eq("bp_ready", bus.Cmd_Ready, 1'b0);
      check_eq("bp_bus", {bus.Select, bus.Opcode}, 7'h0C);
    end
    bus.Cmd_Valid = 1'b0;
    bus.Rsp_Ready = 1'b1;
    tick;
    bus.Rsp_Ready = 1'b0;
    check_eq("bp_release", {bus.Rsp_Valid, bus.Cmd_Ready}, 2'b01);
    tick;
    check_eq("bp_not_taken", {bus.Select, bus.Cmd_Ready, bus.Rsp_Valid}, 5'b00010);
    shift_flag_cfg = 1'b1;

    // Reset during EXEC drops the command
    bus.Cmd_Valid = 1'b1; bus.Cmd_Opcode = 4'b0111; bus.Cmd_A = 8'hFF; bus.Cmd_B = 8'h0F;
    tick;
    bus.Cmd_Valid = 1'b0;
    check_eq("mid_exec_sel", bus.Select, 3'b010);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("mid_rst_ctrl", {bus.Cmd_Ready, bus.Select, bus.Rsp_Valid}, 5'b10000);
    check_eq("mid_rst_bus", {bus.Opcode, bus.A, bus.B}, 20'h0);
    check_eq("mid_rst_rsp", {bus.Rsp_Err, bus.Rsp_Result}, 9'h0);
    bus.Rsp_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq("mid_no_rsp", bus.Rsp_Valid, 1'b0);
    end
    bus.Rsp_Ready = 1'b0;

    run_cmd("add", 4'b0000, 8'h12, 8'h34, 3, 8'h46, 1'b0);
    run_cmd("xor", 4'b1010, 8'hF0, 8'h3C, 3, 8'hCC, 1'b0);
    run_cmd("nor", 4'b1001, 8'h0F, 8'h30, 3, 8'hC0, 1'b0);

    // Counter sequence from a clean reset: 3 legal, 2 reserved
    rst = 1'b1;
    tick;
    rst = 1'b0;
`ifdef ALU_ISSUE_STATS_EN
    check_eq("stat_rst", {stat_ops, stat_errs}, 32'h0);
`endif
    run_cmd("s_add", 4'b0000, 8'h01, 8'h02, 3, 8'h03, 1'b0);
    run_cmd("s_and", 4'b0110, 8'hFF, 8'h0F, 3, 8'h0F, 1'b0);
    run_cmd("s_shr", 4'b1101, 8'h80, 8'h00, 3, 8'h40, 1'b0);
    run_cmd("s_rsv1", 4'b1111, 8'h00, 8'h00, 1, 8'h00, 1'b1);
    run_cmd("s_rsv0", 4'b1110, 8'h00, 8'h00, 1, 8'h00, 1'b1);
`ifdef ALU_ISSUE_STATS_EN
    check_eq("stat_ops", stat_ops, 16'd5);
    check_eq("stat_errs", stat_errs, 16'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
